lvds_rx_align: RTL and testbench
================================

Name: lvds_rx_align

Overview:
- Parametrised, self-training word aligner for the 7:1 LVDS receive path. Runs in the divided-clock (parallel) domain, downstream of the per-lane ISERDESE2 instances.
- Per lane, it drives the ISERDES BITSLIP input until the deserialised word matches a training pattern. It then holds lock and presents aligned, registered parallel data with a valid flag.
- Generalises the fixed 4-lane, 7-bit deserialiser front end to N lanes, any word width, and automatic alignment with pass/fail reporting.

Parameters:
- NUM_LANES, 4, number of LVDS data lanes.
- DATA_WIDTH, 7, bits per lane word (2..8; matches ISERDES DATA_WIDTH).
- TRAIN_PATTERN, 7'b1100011, per-lane training word expected once aligned; width DATA_WIDTH.
- LOCK_COUNT, 16, consecutive matching words required to declare lane lock (1..255).
- SLIP_WAIT, 3, idle clk cycles after each bitslip pulse before re-checking (covers ISERDES slip latency; ≥2).

Ports:
- clk  in  1  divided clock (ISERDES CLKDIV domain); all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- train_start  in  1  single-cycle pulse; (re)starts training on all lanes.
- din  in  NUM_LANES*DATA_WIDTH  ISERDES Q outputs; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- bitslip  out  NUM_LANES  one-cycle bitslip pulse per lane, to the ISERDES BITSLIP pin.
- dout  out  NUM_LANES*DATA_WIDTH  registered copy of din, same lane packing.
- dout_valid  out  1  high while all lanes are locked.
- lane_locked  out  NUM_LANES  per-lane lock status.
- train_fail  out  NUM_LANES  per-lane sticky failure: no alignment found.
- busy  out  1  OR of all lanes in CHECK/SLIP/WAIT.

Behaviour:
- Reset: all outputs 0; every lane FSM in IDLE; all counters 0.
- Per-lane FSM states: IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
- IDLE:
  - on train_start → CHECK; clear match_cnt, slip_cnt and train_fail.
  - train_start in any other state also forces → CHECK with the same clears (restart mid-operation).
- CHECK: compare the lane word with TRAIN_PATTERN each cycle.
  - Match → match_cnt++. When match_cnt reaches LOCK_COUNT-1 while matching → LOCKED.
  - Mismatch → match_cnt=0, then → SLIP, or → FAIL if slip_cnt == DATA_WIDTH (full rotation exhausted).
- SLIP:
  - bitslip[k]=1 for exactly one cycle; slip_cnt++ (saturates at DATA_WIDTH); → WAIT.
- WAIT:
  - count SLIP_WAIT cycles with bitslip=0; → CHECK.
- LOCKED:
  - lane_locked[k]=1; stays until train_start or reset. Data is not re-checked; payload may differ from the pattern.
- FAIL:
  - train_fail[k]=1 (sticky); lane_locked=0; exits only on train_start or reset.
- bitslip is never asserted on consecutive cycles; minimum spacing is SLIP_WAIT+1.
- Datapath:
  - dout <= din every cycle: one-cycle latency, independent of lock.
  - dout_valid <= &lane_locked, registered, so it is aligned with dout.
- dout_valid falls the cycle after train_start is registered.
- Lanes train independently and concurrently. All-lanes-locked occurs when the slowest lane locks.
- A pattern equal to one of its own rotations has ambiguous alignment. The first matching rotation is accepted; no error is raised.

Optional Feature:
- Macro LVDS_RX_ALIGN_MONITOR_EN.
- Defined:
  - Adds output mon_err_cnt (16 bits).
  - Lane 0 is treated as a continuous clock lane carrying TRAIN_PATTERN.
  - While lane 0 is LOCKED, each cycle its word ≠ TRAIN_PATTERN increments mon_err_cnt, saturating at 16'hFFFF.
  - Cleared on reset and on train_start.
- Not defined:
  - Port and logic absent; lane 0 behaves as a plain data lane.

Decomposition:
- Package lvds_rx_pkg:
  - lane FSM state enum (IDLE=0, CHECK, SLIP, WAIT, LOCKED, FAIL).
  - default pattern constant LVDS_TRAIN_PAT_7B = 7'b1100011.
- Sub-module lvds_lane_align: one lane FSM with its match, slip and wait counters. Generate-instantiated NUM_LANES times.
- The top level holds the dout/dout_valid registers, busy and train_fail aggregation, and the optional monitor.

Test Plan:
- Bench ISERDES model: rotates each lane word left by 1 the 2nd cycle after a bitslip pulse.
- Pre-aligned: all lanes already at 7'b1100011, pulse train_start → zero bitslips; lane_locked=4'hF 16 cycles after CHECK entry; dout_valid one cycle later.
- Skewed: lane offsets 0,1,3,6 rotations → bitslip counts 0,1,3,6 per lane, never on back-to-back cycles; all lanes lock; dout_valid=1.
- No pattern: lane 2 driven 7'h00 constantly → 7 slips, then train_fail=4'b0100, lane_locked=4'b1011, dout_valid=0, busy=0.
- Mid-train restart: pulse train_start during lane SLIP/WAIT → counters clear, train_fail clears, retraining completes normally. Async rst_n low mid-training → all outputs 0 immediately.
- Glitch during count: one mismatching word at match 10 of 16 → match_cnt resets, one extra bitslip, lock delayed accordingly.
- Monitor (LVDS_RX_ALIGN_MONITOR_EN): after lock, inject 3 corrupt words on lane 0 → mon_err_cnt=3; train_start → 0. With 70000 errors → 16'hFFFF.

Source files
------------

// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the LVDS receive word aligner.
package lvds_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    WAIT   = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } lane_state_e;

  localparam logic [6:0] LVDS_TRAIN_PAT_7B = 7'b1100011;

endpackage

// File: rtl/lvds_lane_align.sv
// Single-lane training FSM: pulses BITSLIP until the lane word matches the
// training pattern LOCK_COUNT times in a row, or gives up after a full rotation.
module lvds_lane_align
  import lvds_rx_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 7,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(LVDS_TRAIN_PAT_7B),
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    SLIP_WAIT     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_train_start,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic                  o_bitslip,
  output logic                  o_locked,
  output logic                  o_fail,
  output logic                  o_busy
);

  localparam int                 SLIP_W     = $clog2(DATA_WIDTH + 1);
  localparam int                 WAIT_W     = $clog2(SLIP_WAIT + 1);
  localparam logic [SLIP_W-1:0]  SLIP_MAX   = SLIP_W'(DATA_WIDTH);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [7:0]         MATCH_LAST = 8'(LOCK_COUNT - 1);

  lane_state_e       r_state, w_state_nxt;
  logic [7:0]        r_match_cnt, w_match_nxt;
  logic [SLIP_W-1:0] r_slip_cnt, w_slip_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_match_cnt <= '0;
      r_slip_cnt  <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
      r_slip_cnt  <= w_slip_nxt;
      r_wait_cnt  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_slip_nxt  = r_slip_cnt;
    w_wait_nxt  = r_wait_cnt;
    // train_start overrides every state, including LOCKED and FAIL
    if (i_train_start) begin
      w_state_nxt = CHECK;
      w_match_nxt = '0;
      w_slip_nxt  = '0;
      w_wait_nxt  = '0;
    end else begin
      case (r_state)
        CHECK: begin
          if (i_din == TRAIN_PATTERN) begin
            if (r_match_cnt == MATCH_LAST) w_state_nxt = LOCKED;
            else                           w_match_nxt = r_match_cnt + 8'd1;
          end else begin
            w_match_nxt = '0;
            w_state_nxt = (r_slip_cnt == SLIP_MAX) ? FAIL : SLIP;
          end
        end
        SLIP: begin
          if (r_slip_cnt != SLIP_MAX) w_slip_nxt = r_slip_cnt + SLIP_W'(1);
          w_wait_nxt  = '0;
          w_state_nxt = WAIT;
        end
        WAIT: begin
          if (r_wait_cnt == WAIT_LAST) w_state_nxt = CHECK;
          else                         w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_bitslip = (r_state == SLIP);
  assign o_locked  = (r_state == LOCKED);
  assign o_fail    = (r_state == FAIL);
  assign o_busy    = (r_state == CHECK) || (r_state == SLIP) || (r_state == WAIT);

endmodule

// File: rtl/lvds_rx_align.sv
// N-lane self-training word aligner for the ISERDES parallel domain.
// Define LVDS_RX_ALIGN_MONITOR_EN to add a lane-0 clock-pattern error counter.
module lvds_rx_align
  import lvds_rx_pkg::*;
#(
  parameter int                    NUM_LANES     = 4,
  parameter int                    DATA_WIDTH    = 7,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(LVDS_TRAIN_PAT_7B),
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    SLIP_WAIT     = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            train_start,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] din,
  output logic [NUM_LANES-1:0]            bitslip,
  output logic [NUM_LANES*DATA_WIDTH-1:0] dout,
  output logic                            dout_valid,
  output logic [NUM_LANES-1:0]            lane_locked,
  output logic [NUM_LANES-1:0]            train_fail,
  output logic                            busy
`ifdef LVDS_RX_ALIGN_MONITOR_EN
  ,
  output logic [15:0]                     mon_err_cnt
`endif
);

  logic [NUM_LANES-1:0]            w_bitslip, w_locked, w_fail, w_busy;
  logic [NUM_LANES*DATA_WIDTH-1:0] r_dout_p1;
  logic                            r_vld_p1;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lvds_lane_align #(
      .DATA_WIDTH    (DATA_WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .LOCK_COUNT    (LOCK_COUNT),
      .SLIP_WAIT     (SLIP_WAIT)
    ) u_lane (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_train_start (train_start),
      .i_din         (din[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_bitslip     (w_bitslip[g]),
      .o_locked      (w_locked[g]),
      .o_fail        (w_fail[g]),
      .o_busy        (w_busy[g])
    );
  end

  // Stage p0 -> p1: data and its valid leave together one cycle after din
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_dout_p1 <= din;
      r_vld_p1  <= &w_locked;
    end
  end

  assign bitslip     = w_bitslip;
  assign lane_locked = w_locked;
  assign train_fail  = w_fail;
  assign busy        = |w_busy;
  assign dout        = r_dout_p1;
  assign dout_valid  = r_vld_p1;

`ifdef LVDS_RX_ALIGN_MONITOR_EN
  logic [15:0] r_mon_err_cnt;

  // Lane 0 carries the forwarded clock, so any deviation after lock is a bit error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mon_err_cnt <= '0;
    end else if (train_start) begin
      r_mon_err_cnt <= '0;
    end else if (w_locked[0] && (din[DATA_WIDTH-1:0] != TRAIN_PATTERN) &&
                 (r_mon_err_cnt != 16'hFFFF)) begin
      r_mon_err_cnt <= r_mon_err_cnt + 16'd1;
    end
  end

  assign mon_err_cnt = r_mon_err_cnt;
`endif

endmodule

// File: tb/tb_lvds_rx_align.sv
// Directed bench for lvds_rx_align with a behavioural ISERDES bitslip model.
`timescale 1ns/1ps
module tb_lvds_rx_align;

  localparam int             NL  = 4;
  localparam int             DW  = 7;
  localparam logic [DW-1:0]  PAT = 7'b1100011;

  logic              clk         = 1'b0;
  logic              rst_n       = 1'b0;
  logic              train_start = 1'b0;
  logic [NL*DW-1:0]  din;
  logic [NL-1:0]     bitslip, lane_locked, train_fail;
  logic [NL*DW-1:0]  dout;
  logic              dout_valid, busy;
`ifdef LVDS_RX_ALIGN_MONITOR_EN
  logic [15:0]       mon_err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  int            rot   [NL] = '{default: 0};
  int            slips [NL] = '{default: 0};
  int            base  [NL] = '{default: 0};
  int            s0    [NL] = '{default: 0};
  int            b2b        = 0;
  logic [NL-1:0] bs_d1      = '0;
  logic [NL-1:0] zmask      = '0;
  logic [NL-1:0] gmask      = '0;
  logic          rot_en     = 1'b1;
  logic [NL*DW-1:0] aligned = {NL{PAT}};
  logic [NL*DW-1:0] exp_dout;

  typedef struct packed {
    logic [NL-1:0][2:0] off;
    logic [NL-1:0]      z;
    logic [NL-1:0][3:0] slp;
    logic [NL-1:0]      lock;
    logic [NL-1:0]      fail;
    logic               valid;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  lvds_rx_align #(
    .NUM_LANES     (NL),
    .DATA_WIDTH    (DW),
    .TRAIN_PATTERN (PAT),
    .LOCK_COUNT    (16),
    .SLIP_WAIT     (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .train_start (train_start),
    .din         (din),
    .bitslip     (bitslip),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .lane_locked (lane_locked),
    .train_fail  (train_fail),
    .busy        (busy)
`ifdef LVDS_RX_ALIGN_MONITOR_EN
    ,
    .mon_err_cnt (mon_err_cnt)
`endif
  );

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] w, input int n);
    logic [DW-1:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[DW-2:0], r[DW-1]};
    return r;
  endfunction

  // ISERDES model: a bitslip pulse rotates the word left by one, two cycles later
  always @(posedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (bs_d1[k] && rot_en) rot[k] <= (rot[k] + 1) % DW;
      if (bitslip[k]) begin
        slips[k] <= slips[k] + 1;
        if (bs_d1[k]) b2b <= b2b + 1;
      end
    end
    bs_d1 <= bitslip;
  end

  always_comb begin
    din = '0;
    for (int k = 0; k < NL; k++) begin
      if (!zmask[k]) begin
        if (gmask[k]) din[k*DW +: DW] = ~rotl(PAT, (base[k] + rot[k]) % DW);
        else          din[k*DW +: DW] =  rotl(PAT, (base[k] + rot[k]) % DW);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Lane k starts 'off' left-rotations short of alignment
  task automatic set_offsets(input logic [NL-1:0][2:0] off, input logic [NL-1:0] z);
    for (int k = 0; k < NL; k++) begin
      base[k] = (2*DW - int'(off[k]) - (rot[k] % DW)) % DW;
      s0[k]   = slips[k];
    end
    zmask = z;
  endtask

  task automatic pulse_start();
    @(negedge clk); train_start = 1'b1;
    @(negedge clk); train_start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{off: {3'd0, 3'd0, 3'd0, 3'd0}, z: 4'b0000, slp: {4'd0, 4'd0, 4'd0, 4'd0},
               lock: 4'hF, fail: 4'h0, valid: 1'b1};
    tbl[1] = '{off: {3'd6, 3'd3, 3'd1, 3'd0}, z: 4'b0000, slp: {4'd6, 4'd3, 4'd1, 4'd0},
               lock: 4'hF, fail: 4'h0, valid: 1'b1};
    tbl[2] = '{off: {3'd0, 3'd4, 3'd5, 3'd2}, z: 4'b0000, slp: {4'd0, 4'd4, 4'd5, 4'd2},
               lock: 4'hF, fail: 4'h0, valid: 1'b1};
    tbl[3] = '{off: {3'd0, 3'd0, 3'd0, 3'd0}, z: 4'b0100, slp: {4'd0, 4'd7, 4'd0, 4'd0},
               lock: 4'b1011, fail: 4'b0100, valid: 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_bitslip", {28'd0, bitslip}, 32'd0);
    check("rst_dout", {4'd0, dout}, 32'd0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_locked", {28'd0, lane_locked}, 32'd0);
    check("rst_fail", {28'd0, train_fail}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef LVDS_RX_ALIGN_MONITOR_EN
    check("rst_mon", {16'd0, mon_err_cnt}, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Pre-aligned: exact lock latency
    set_offsets({3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000);
    pulse_start();
    check("pre_busy", {31'd0, busy}, 32'd1);
    check("pre_locked0", {28'd0, lane_locked}, 32'd0);
    repeat (15) @(negedge clk);
    check("pre_locked15", {28'd0, lane_locked}, 32'd0);
    @(negedge clk);
    check("pre_locked16", {28'd0, lane_locked}, 32'hF);
    check("pre_valid16", {31'd0, dout_valid}, 32'd0);
    @(negedge clk);
    check("pre_valid17", {31'd0, dout_valid}, 32'd1);
    check("pre_dout", {4'd0, dout}, {4'd0, aligned});
    for (int k = 0; k < NL; k++)
      check($sformatf("pre_slips_l%0d", k), slips[k] - s0[k], 32'd0);

    // Table of alignment scenarios
    for (int i = 0; i < 4; i++) begin
      set_offsets(tbl[i].off, tbl[i].z);
      pulse_start();
      wait_idle(300);
      @(negedge clk);
      for (int k = 0; k < NL; k++)
        exp_dout[k*DW +: DW] = tbl[i].z[k] ? '0 : PAT;
      check($sformatf("v%0d_locked", i), {28'd0, lane_locked}, {28'd0, tbl[i].lock});
      check($sformatf("v%0d_fail", i), {28'd0, train_fail}, {28'd0, tbl[i].fail});
      check($sformatf("v%0d_valid", i), {31'd0, dout_valid}, {31'd0, tbl[i].valid});
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_dout", i), {4'd0, dout}, {4'd0, exp_dout});
      for (int k = 0; k < NL; k++)
        check($sformatf("v%0d_slips_l%0d", i, k), slips[k] - s0[k], {28'd0, tbl[i].slp[k]});
    end
    check("no_b2b_bitslip", b2b, 32'd0);

    // Restart from FAIL, then again mid-slip
    set_offsets({3'd6, 3'd3, 3'd1, 3'd0}, 4'b0000);
    pulse_start();
    check("rs_fail_clr", {28'd0, train_fail}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    pulse_start();
    check("rs2_bitslip", {28'd0, bitslip}, 32'd0);
    check("rs2_busy", {31'd0, busy}, 32'd1);
    wait_idle(300);
    @(negedge clk);
    check("rs2_locked", {28'd0, lane_locked}, 32'hF);
    check("rs2_fail", {28'd0, train_fail}, 32'd0);
    check("rs2_valid", {31'd0, dout_valid}, 32'd1);
    check("rs2_dout", {4'd0, dout}, {4'd0, aligned});

    // Asynchronous reset while locked, then while training
    @(negedge clk); #2 rst_n = 1'b0; #1;
    check("ar_locked", {28'd0, lane_locked}, 32'd0);
    check("ar_valid", {31'd0, dout_valid}, 32'd0);
    check("ar_dout", {4'd0, dout}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    set_offsets({3'd6, 3'd3, 3'd1, 3'd0}, 4'b0000);
    pulse_start();
    repeat (4) @(negedge clk);
    check("ar2_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0; #1;
    check("ar2_busy", {31'd0, busy}, 32'd0);
    check("ar2_bitslip", {28'd0, bitslip}, 32'd0);
    check("ar2_fail", {28'd0, train_fail}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single glitch at match 10 on lane 0 costs one slip and 15 cycles
    rot_en = 1'b0;
    set_offsets({3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000);
    pulse_start();
    repeat (10) @(negedge clk);
    gmask = 4'b0001;
    @(negedge clk);
    gmask = 4'b0000;
    check("gl_bitslip", {28'd0, bitslip}, 32'b0001);
    repeat (5) @(negedge clk);
    check("gl_locked16", {28'd0, lane_locked}, 32'b1110);
    repeat (14) @(negedge clk);
    check("gl_locked30", {28'd0, lane_locked}, 32'b1110);
    @(negedge clk);
    check("gl_locked31", {28'd0, lane_locked}, 32'hF);
    @(negedge clk);
    check("gl_valid", {31'd0, dout_valid}, 32'd1);
    check("gl_slips_l0", slips[0] - s0[0], 32'd1);
    check("gl_slips_l1", slips[1] - s0[1], 32'd0);
    rot_en = 1'b1;

`ifdef LVDS_RX_ALIGN_MONITOR_EN
    // Lane-0 error monitor
    check("mon_idle", {16'd0, mon_err_cnt}, 32'd0);
    @(negedge clk); gmask = 4'b0001;
    repeat (3) @(negedge clk);
    gmask = 4'b0000;
    check("mon_3", {16'd0, mon_err_cnt}, 32'd3);
    @(negedge clk);
    check("mon_3_hold", {16'd0, mon_err_cnt}, 32'd3);
    pulse_start();
    check("mon_clr", {16'd0, mon_err_cnt}, 32'd0);
    wait_idle(300);
    @(negedge clk); gmask = 4'b0001;
    repeat (70000) @(negedge clk);
    gmask = 4'b0000;
    check("mon_sat", {16'd0, mon_err_cnt}, 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
